fetch_stage: RTL and testbench

FETCH_STAGE -- requirements
Module: fetch_stage

---
 rtl/fetch_stage.sv | 181 ++++++++++++++++++
 tb/tb_fetch_stage.sv | 252 +++++++++++++++++++++++++
 2 files changed

// File: rtl/fetch_stage.sv
// Instruction fetch stage: PC register, single-outstanding imem handshake FSM and IF/ID register.
// Optional macro FETCH_NOP_ON_FLUSH_EN makes flushed/bubbled instr_d an addi x0,x0,0 instead of zero.
module fetch_stage #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        stall_f,
  input  logic        flush_d,
  input  logic        pc_src_e,
  input  logic [31:0] pc_target_e,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  output logic [31:0] instr_d,
  output logic [31:0] pc_d,
  output logic [31:0] pc_plus4_d,
  output logic        valid_d
);

`ifdef FETCH_NOP_ON_FLUSH_EN
  localparam logic [31:0] FLUSH_INSTR = 32'h0000_0013;
`else
  localparam logic [31:0] FLUSH_INSTR = 32'h0000_0000;
`endif

  typedef enum logic [1:0] {
    IDLE,
    REQ,
    HOLD,
    KILL
  } state_t;

  typedef enum logic [1:0] {
    IFID_KEEP,
    IFID_LOAD_MEM,
    IFID_LOAD_HOLD,
    IFID_BUBBLE
  } ifid_act_t;

  state_t      r_state;
  state_t      w_state_nxt;
  ifid_act_t   w_ifid_act;

  logic [31:0] r_pc_f;
  logic [31:0] w_pc_nxt;
  logic [31:0] w_pc_plus4;

  logic [31:0] r_hold_instr;
  logic [31:0] r_hold_pc;
  logic [31:0] w_hold_plus4;
  logic        w_hold_capture;

  logic [31:0] r_instr_d;
  logic [31:0] r_pc_d;
  logic [31:0] r_pc_plus4_d;
  logic        r_valid_d;
  logic [31:0] w_instr_nxt;
  logic [31:0] w_pc_d_nxt;
  logic [31:0] w_pc_plus4_nxt;
  logic        w_valid_nxt;

  assign w_pc_plus4   = r_pc_f + 32'd4;
  assign w_hold_plus4 = r_hold_pc + 32'd4;

  assign imem_req   = (r_state == REQ);
  assign imem_addr  = r_pc_f;
  assign instr_d    = r_instr_d;
  assign pc_d       = r_pc_d;
  assign pc_plus4_d = r_pc_plus4_d;
  assign valid_d    = r_valid_d;

  // Next-state, next-PC and IF/ID action; a redirect always wins over stall and drops any held word.
  always_comb begin
    w_state_nxt    = r_state;
    w_pc_nxt       = r_pc_f;
    w_ifid_act     = IFID_KEEP;
    w_hold_capture = 1'b0;
    case (r_state)
      IDLE: begin
        w_state_nxt = REQ;
        if (pc_src_e) w_pc_nxt = pc_target_e;
      end
      REQ: begin
        if (pc_src_e) begin
          w_pc_nxt    = pc_target_e;
          w_state_nxt = imem_rvalid ? REQ : KILL;
          w_ifid_act  = stall_f ? IFID_KEEP : IFID_BUBBLE;
        end else if (imem_rvalid && !stall_f) begin
          w_pc_nxt   = w_pc_plus4;
          w_ifid_act = IFID_LOAD_MEM;
        end else if (imem_rvalid) begin
          w_hold_capture = 1'b1;
          w_state_nxt    = HOLD;
        end else if (!stall_f) begin
          w_ifid_act = IFID_BUBBLE;
        end
      end
      HOLD: begin
        if (pc_src_e) begin
          w_pc_nxt    = pc_target_e;
          w_state_nxt = REQ;
          w_ifid_act  = stall_f ? IFID_KEEP : IFID_BUBBLE;
        end else if (!stall_f) begin
          w_pc_nxt    = w_hold_plus4;
          w_state_nxt = REQ;
          w_ifid_act  = IFID_LOAD_HOLD;
        end
      end
      KILL: begin
        // Wait here for the stale response so it can never be mistaken for the redirected fetch.
        if (pc_src_e) w_pc_nxt = pc_target_e;
        if (imem_rvalid) w_state_nxt = REQ;
        w_ifid_act = stall_f ? IFID_KEEP : IFID_BUBBLE;
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  // IF/ID next contents; flush overrides every other action.
  always_comb begin
    w_instr_nxt    = r_instr_d;
    w_pc_d_nxt     = r_pc_d;
    w_pc_plus4_nxt = r_pc_plus4_d;
    w_valid_nxt    = r_valid_d;
    if (flush_d) begin
      w_instr_nxt    = FLUSH_INSTR;
      w_pc_d_nxt     = 32'd0;
      w_pc_plus4_nxt = 32'd0;
      w_valid_nxt    = 1'b0;
    end else begin
      case (w_ifid_act)
        IFID_LOAD_MEM: begin
          w_instr_nxt    = imem_rdata;
          w_pc_d_nxt     = r_pc_f;
          w_pc_plus4_nxt = w_pc_plus4;
          w_valid_nxt    = 1'b1;
        end
        IFID_LOAD_HOLD: begin
          w_instr_nxt    = r_hold_instr;
          w_pc_d_nxt     = r_hold_pc;
          w_pc_plus4_nxt = w_hold_plus4;
          w_valid_nxt    = 1'b1;
        end
        IFID_BUBBLE: begin
          w_instr_nxt    = FLUSH_INSTR;
          w_pc_d_nxt     = 32'd0;
          w_pc_plus4_nxt = 32'd0;
          w_valid_nxt    = 1'b0;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state      <= IDLE;
      r_pc_f       <= RESET_PC;
      r_hold_instr <= 32'd0;
      r_hold_pc    <= 32'd0;
      r_instr_d    <= 32'd0;
      r_pc_d       <= 32'd0;
      r_pc_plus4_d <= 32'd0;
      r_valid_d    <= 1'b0;
    end else begin
      r_state      <= w_state_nxt;
      r_pc_f       <= w_pc_nxt;
      r_instr_d    <= w_instr_nxt;
      r_pc_d       <= w_pc_d_nxt;
      r_pc_plus4_d <= w_pc_plus4_nxt;
      r_valid_d    <= w_valid_nxt;
      if (w_hold_capture) begin
        r_hold_instr <= imem_rdata;
        r_hold_pc    <= r_pc_f;
      end
    end
  end

endmodule

// File: tb/tb_fetch_stage.sv
// Directed self-checking bench for fetch_stage; memory returns addr ^ 0xCAFE0000 or a fixed word.
module tb_fetch_stage;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        stall_f;
  logic        flush_d;
  logic        pc_src_e;
  logic [31:0] pc_target_e;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_rvalid;
  logic [31:0] imem_rdata;
  logic [31:0] instr_d;
  logic [31:0] pc_d;
  logic [31:0] pc_plus4_d;
  logic        valid_d;

  logic        memXor;
  logic [31:0] memConst;
  int          checkCount = 0;
  int          passCount = 0;

`ifdef FETCH_NOP_ON_FLUSH_EN
  localparam logic [31:0] EXP_FLUSH = 32'h0000_0013;
`else
  localparam logic [31:0] EXP_FLUSH = 32'h0000_0000;
`endif

  fetch_stage #(.RESET_PC(32'h0000_0000)) dut (
    .clk(clk), .rst_n(rst_n), .stall_f(stall_f), .flush_d(flush_d),
    .pc_src_e(pc_src_e), .pc_target_e(pc_target_e),
    .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
    .instr_d(instr_d), .pc_d(pc_d), .pc_plus4_d(pc_plus4_d), .valid_d(valid_d)
  );

  always #5 clk = ~clk;

  // Memory data model: the bench only chooses which word pattern is on the bus.
  always_comb imem_rdata = memXor ? (imem_addr ^ 32'hCAFE_0000) : memConst;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic doReset();
    rst_n = 1'b0; stall_f = 1'b0; flush_d = 1'b0; pc_src_e = 1'b0;
    pc_target_e = 32'd0;
    tick();
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    memXor = 1'b1; memConst = 32'd0; imem_rvalid = 1'b1;
    doReset();
    checkCount++;
    if ({imem_req, valid_d, instr_d, pc_d, pc_plus4_d} !== {1'b0, 1'b0, 96'd0})
      $display("[TB] FAIL reset_state: req=%b valid=%b instr=%h pc=%h p4=%h want all zero",
               imem_req, valid_d, instr_d, pc_d, pc_plus4_d);
    else passCount++;
  endtask

  task automatic test_stream();
    memXor = 1'b0; memConst = 32'h0000_00A5; imem_rvalid = 1'b1;
    doReset();
    tick();
    checkCount++;
    if (imem_req !== 1'b1 || imem_addr !== 32'd0)
      $display("[TB] FAIL stream_first_req: req=%b addr=%h want 1/00000000", imem_req, imem_addr);
    else passCount++;
    tick();
    checkCount++;
    if ({instr_d, pc_d, pc_plus4_d, valid_d} !== {32'hA5, 32'd0, 32'd4, 1'b1})
      $display("[TB] FAIL stream_first_instr: instr=%h pc=%h p4=%h v=%b want a5/0/4/1",
               instr_d, pc_d, pc_plus4_d, valid_d);
    else passCount++;
    checkCount++;
    if (imem_addr !== 32'd4) $display("[TB] FAIL stream_addr4: got %h want 00000004", imem_addr);
    else passCount++;
    tick();
    checkCount++;
    if (imem_addr !== 32'd8 || pc_d !== 32'd4)
      $display("[TB] FAIL stream_addr8: addr=%h pc_d=%h want 8/4", imem_addr, pc_d);
    else passCount++;
  endtask

  task automatic test_latency();
    memXor = 1'b1; imem_rvalid = 1'b0;
    doReset();
    tick();
    for (int i = 0; i < 2; i++) begin
      tick();
      checkCount++;
      if (valid_d !== 1'b0 || imem_addr !== 32'(4 * i) || imem_req !== 1'b1)
        $display("[TB] FAIL latency_wait%0d: v=%b addr=%h req=%b want 0/%h/1",
                 i, valid_d, imem_addr, imem_req, 32'(4 * i));
      else passCount++;
      imem_rvalid = 1'b1;
      tick();
      imem_rvalid = 1'b0;
      checkCount++;
      if ({valid_d, pc_d, instr_d, imem_addr} !==
          {1'b1, 32'(4 * i), 32'hCAFE_0000 | 32'(4 * i), 32'(4 * i + 4)})
        $display("[TB] FAIL latency_load%0d: v=%b pc=%h instr=%h addr=%h",
                 i, valid_d, pc_d, instr_d, imem_addr);
      else passCount++;
    end
  endtask

  task automatic test_stall_hold();
    memXor = 1'b1; imem_rvalid = 1'b1;
    doReset();
    tick(); tick(); tick();
    stall_f = 1'b1;
    tick();
    checkCount++;
    if ({imem_req, pc_d, instr_d, valid_d} !== {1'b0, 32'd4, 32'hCAFE_0004, 1'b1})
      $display("[TB] FAIL stall_hold_enter: req=%b pc=%h instr=%h v=%b want 0/4/cafe0004/1",
               imem_req, pc_d, instr_d, valid_d);
    else passCount++;
    tick();
    checkCount++;
    if (imem_req !== 1'b0 || pc_d !== 32'd4)
      $display("[TB] FAIL stall_hold_stay: req=%b pc=%h want 0/4", imem_req, pc_d);
    else passCount++;
    stall_f = 1'b0;
    tick();
    checkCount++;
    if ({instr_d, pc_d, pc_plus4_d, valid_d, imem_req, imem_addr} !==
        {32'hCAFE_0008, 32'd8, 32'd12, 1'b1, 1'b1, 32'd12})
      $display("[TB] FAIL stall_release: instr=%h pc=%h p4=%h v=%b req=%b addr=%h",
               instr_d, pc_d, pc_plus4_d, valid_d, imem_req, imem_addr);
    else passCount++;
    tick();
    checkCount++;
    if (pc_d !== 32'd12 || instr_d !== 32'hCAFE_000C)
      $display("[TB] FAIL stall_after: pc=%h instr=%h want c/cafe000c", pc_d, instr_d);
    else passCount++;
  endtask

  task automatic test_redirect_kill();
    memXor = 1'b1; imem_rvalid = 1'b1;
    doReset();
    for (int i = 0; i < 5; i++) tick();
    checkCount++;
    if (imem_req !== 1'b1 || imem_addr !== 32'h10)
      $display("[TB] FAIL kill_setup: req=%b addr=%h want 1/10", imem_req, imem_addr);
    else passCount++;
    imem_rvalid = 1'b0; pc_src_e = 1'b1; pc_target_e = 32'h100;
    tick();
    pc_src_e = 1'b0;
    checkCount++;
    if (imem_req !== 1'b0 || valid_d !== 1'b0)
      $display("[TB] FAIL kill_enter: req=%b v=%b want 0/0", imem_req, valid_d);
    else passCount++;
    memXor = 1'b0; memConst = 32'hDEAD_BEEF; imem_rvalid = 1'b1;
    tick();
    checkCount++;
    if (imem_req !== 1'b1 || imem_addr !== 32'h100 || valid_d !== 1'b0)
      $display("[TB] FAIL kill_drop: req=%b addr=%h v=%b want 1/100/0", imem_req, imem_addr, valid_d);
    else passCount++;
    memXor = 1'b1;
    tick();
    checkCount++;
    if ({pc_d, instr_d, valid_d} !== {32'h100, 32'hCAFE_0100, 1'b1})
      $display("[TB] FAIL kill_deliver: pc=%h instr=%h v=%b want 100/cafe0100/1", pc_d, instr_d, valid_d);
    else passCount++;
  endtask

  task automatic test_flush_stall();
    memXor = 1'b1; imem_rvalid = 1'b1;
    doReset();
    tick(); tick();
    flush_d = 1'b1; stall_f = 1'b1;
    tick();
    flush_d = 1'b0;
    checkCount++;
    if ({valid_d, pc_d, pc_plus4_d, instr_d} !== {1'b0, 32'd0, 32'd0, EXP_FLUSH})
      $display("[TB] FAIL flush_stall: v=%b pc=%h p4=%h instr=%h want 0/0/0/%h",
               valid_d, pc_d, pc_plus4_d, instr_d, EXP_FLUSH);
    else passCount++;
    stall_f = 1'b0;
    tick();
    checkCount++;
    if ({pc_d, instr_d, valid_d} !== {32'd4, 32'hCAFE_0004, 1'b1})
      $display("[TB] FAIL flush_then_hold: pc=%h instr=%h v=%b want 4/cafe0004/1", pc_d, instr_d, valid_d);
    else passCount++;
  endtask

  task automatic test_reset_midflight();
    memXor = 1'b1; imem_rvalid = 1'b1;
    doReset();
    tick(); tick();
    imem_rvalid = 1'b0;
    tick();
    rst_n = 1'b0; imem_rvalid = 1'b1;
    tick();
    checkCount++;
    if ({imem_req, valid_d, instr_d, pc_d, pc_plus4_d} !== {1'b0, 1'b0, 96'd0})
      $display("[TB] FAIL midreset_state: req=%b v=%b instr=%h pc=%h p4=%h want zero",
               imem_req, valid_d, instr_d, pc_d, pc_plus4_d);
    else passCount++;
    rst_n = 1'b1; memXor = 1'b0; memConst = 32'hBAD0_0BAD;
    tick();
    checkCount++;
    if ({imem_req, imem_addr, valid_d, instr_d} !== {1'b1, 32'd0, 1'b0, 32'd0})
      $display("[TB] FAIL midreset_ignore: req=%b addr=%h v=%b instr=%h want 1/0/0/0",
               imem_req, imem_addr, valid_d, instr_d);
    else passCount++;
    memXor = 1'b1;
    tick();
    checkCount++;
    if ({pc_d, instr_d, valid_d} !== {32'd0, 32'hCAFE_0000, 1'b1})
      $display("[TB] FAIL midreset_first: pc=%h instr=%h v=%b want 0/cafe0000/1", pc_d, instr_d, valid_d);
    else passCount++;
  endtask

  task automatic test_pc_wrap();
    memXor = 1'b1; imem_rvalid = 1'b1;
    doReset();
    tick();
    pc_src_e = 1'b1; pc_target_e = 32'hFFFF_FFFC;
    tick();
    pc_src_e = 1'b0;
    checkCount++;
    if (imem_addr !== 32'hFFFF_FFFC || valid_d !== 1'b0)
      $display("[TB] FAIL wrap_redirect: addr=%h v=%b want fffffffc/0", imem_addr, valid_d);
    else passCount++;
    tick();
    checkCount++;
    if ({pc_d, pc_plus4_d, instr_d, imem_addr} !== {32'hFFFF_FFFC, 32'd0, 32'h3501_FFFC, 32'd0})
      $display("[TB] FAIL wrap_load: pc=%h p4=%h instr=%h addr=%h want fffffffc/0/3501fffc/0",
               pc_d, pc_plus4_d, instr_d, imem_addr);
    else passCount++;
  endtask

  initial begin
    test_reset();
    test_stream();
    test_latency();
    test_stall_hold();
    test_redirect_kill();
    test_flush_stall();
    test_reset_midflight();
    test_pc_wrap();
    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule
